// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the 8-point FFT frame sequencer.
//   state_e : controller FSM states
//   cplx_t  : one complex sample {re, im}, DW bits per component
package fft_ctrl_pkg;

    localparam int unsigned N_PTS = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned IDX_W = 3;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

endpackage

// File: rtl/fft_sample_buf.sv
// 8-entry complex register file.
//   clk          : rising-edge clock
//   i_clr        : synchronous clear of every entry (highest priority)
//   i_load_en    : parallel load of all entries from i_load_real/i_load_imag
//   i_wr_en      : indexed write of i_wr_data at i_wr_idx
//   o_rd_real/_imag : full packed read port, entry k at [DW*k +: DW]
module fft_sample_buf
    import fft_ctrl_pkg::*;
(
    input  logic                   clk,
    input  logic                   i_clr,
    input  logic                   i_load_en,
    input  logic [N_PTS*DW-1:0]    i_load_real,
    input  logic [N_PTS*DW-1:0]    i_load_imag,
    input  logic                   i_wr_en,
    input  logic [IDX_W-1:0]       i_wr_idx,
    input  cplx_t                  i_wr_data,
    output logic [N_PTS*DW-1:0]    o_rd_real,
    output logic [N_PTS*DW-1:0]    o_rd_imag
);

    logic [N_PTS*DW-1:0] r_real;
    logic [N_PTS*DW-1:0] r_imag;

    // Clear beats parallel load beats indexed write.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_real <= '0;
            r_imag <= '0;
        end else if (i_load_en) begin
            r_real <= i_load_real;
            r_imag <= i_load_imag;
        end else if (i_wr_en) begin
            r_real[DW*32'(i_wr_idx) +: DW] <= i_wr_data.re;
            r_imag[DW*32'(i_wr_idx) +: DW] <= i_wr_data.im;
        end
    end

    assign o_rd_real = r_real;
    assign o_rd_imag = r_imag;

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer in front of an 8-point pipelined FFT core.
// Collects 8 serial samples, starts the FFT, waits for done (with timeout),
// then streams the 8 results out with valid/ready.
//   clk, rst                    : clock, synchronous active-high reset
//   in_valid/in_ready/in_*      : serial sample input
//   fft_start, fft_x_*          : start pulse and packed frame to the FFT
//   fft_done, fft_y_*           : FFT completion and packed results
//   out_valid/out_ready/out_*   : serial result output, out_index = bin
//   busy                        : high in START, WAIT and DRAIN
//   timeout_err                 : one-cycle pulse when a frame is aborted
// DW and N_PTS must match fft_ctrl_pkg (the FFT core is fixed at 8x8 bits).
module fft_frame_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int unsigned N_PTS   = 8,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_real,
    input  logic [DW-1:0]        in_imag,
    output logic                 fft_start,
    output logic [N_PTS*DW-1:0]  fft_x_real,
    output logic [N_PTS*DW-1:0]  fft_x_imag,
    input  logic                 fft_done,
    input  logic [N_PTS*DW-1:0]  fft_y_real,
    input  logic [N_PTS*DW-1:0]  fft_y_imag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DW-1:0]        out_real,
    output logic [DW-1:0]        out_imag,
    output logic [2:0]           out_index,
    output logic                 out_last,
    output logic                 busy,
    output logic                 timeout_err
);

    localparam int unsigned TMR_W   = $clog2(TIMEOUT) + 1;
    localparam int unsigned LAST_IX = N_PTS - 1;

    state_e             r_state;
    state_e             w_state_nxt;
    logic [IDX_W-1:0]   r_wr_idx;
    logic [IDX_W-1:0]   w_wr_idx_nxt;
    logic [IDX_W-1:0]   r_rd_idx;
    logic [IDX_W-1:0]   w_rd_idx_nxt;
    logic [TMR_W-1:0]   r_timer;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic               r_timeout_err;
    logic               w_timeout_nxt;
    logic               w_smp_we;
    logic               w_res_load;
    cplx_t              w_in_smp;
    logic [N_PTS*DW-1:0] w_res_real;
    logic [N_PTS*DW-1:0] w_res_imag;

    assign w_in_smp = '{re: in_real, im: in_imag};

    // Sample buffer: indexed writes during FILL, packed read drives the FFT.
    fft_sample_buf u_smp_buf (
        .clk         (clk),
        .i_clr       (rst),
        .i_load_en   (1'b0),
        .i_load_real ('0),
        .i_load_imag ('0),
        .i_wr_en     (w_smp_we),
        .i_wr_idx    (r_wr_idx),
        .i_wr_data   (w_in_smp),
        .o_rd_real   (fft_x_real),
        .o_rd_imag   (fft_x_imag)
    );

    // Result buffer: parallel load on done, indexed read during DRAIN.
    fft_sample_buf u_res_buf (
        .clk         (clk),
        .i_clr       (rst),
        .i_load_en   (w_res_load),
        .i_load_real (fft_y_real),
        .i_load_imag (fft_y_imag),
        .i_wr_en     (1'b0),
        .i_wr_idx    ('0),
        .i_wr_data   ('0),
        .o_rd_real   (w_res_real),
        .o_rd_imag   (w_res_imag)
    );

    // State, index and timer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= FILL;
            r_wr_idx      <= '0;
            r_rd_idx      <= '0;
            r_timer       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_wr_idx      <= w_wr_idx_nxt;
            r_rd_idx      <= w_rd_idx_nxt;
            r_timer       <= w_timer_nxt;
            r_timeout_err <= w_timeout_nxt;
        end
    end

    // Next-state logic; fft_done is only looked at in WAIT.
    always_comb begin
        w_state_nxt   = r_state;
        w_wr_idx_nxt  = r_wr_idx;
        w_rd_idx_nxt  = r_rd_idx;
        w_timer_nxt   = r_timer;
        w_timeout_nxt = 1'b0;
        w_smp_we      = 1'b0;
        w_res_load    = 1'b0;

        unique case (r_state)
            FILL: begin
                if (in_valid) begin
                    w_smp_we = 1'b1;
                    if (r_wr_idx == IDX_W'(LAST_IX)) begin
                        w_wr_idx_nxt = '0;
                        w_state_nxt  = START;
                    end else begin
                        w_wr_idx_nxt = r_wr_idx + IDX_W'(1);
                    end
                end
            end
            START: begin
                w_timer_nxt = '0;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (fft_done) begin
                    // Done wins even on the cycle the timer would expire.
                    w_res_load   = 1'b1;
                    w_rd_idx_nxt = '0;
                    w_state_nxt  = DRAIN;
                end else begin
                    w_timer_nxt = (r_timer == {TMR_W{1'b1}}) ? r_timer
                                                             : r_timer + TMR_W'(1);
                    if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                        w_timeout_nxt = 1'b1;
                        w_state_nxt   = FILL;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    if (r_rd_idx == IDX_W'(LAST_IX)) begin
                        w_rd_idx_nxt = '0;
                        w_state_nxt  = FILL;
                    end else begin
                        w_rd_idx_nxt = r_rd_idx + IDX_W'(1);
                    end
                end
            end
            default: w_state_nxt = FILL;
        endcase
    end

    // Outputs decoded from state, indices and the result buffer.
    assign in_ready    = (r_state == FILL);
    assign fft_start   = (r_state == START);
    assign busy        = (r_state != FILL);
    assign out_valid   = (r_state == DRAIN);
    assign out_index   = r_rd_idx;
    assign out_last    = (r_state == DRAIN) && (r_rd_idx == IDX_W'(LAST_IX));
    assign out_real    = w_res_real[DW*32'(r_rd_idx) +: DW];
    assign out_imag    = w_res_imag[DW*32'(r_rd_idx) +: DW];
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Directed self-checking bench for fft_frame_ctrl with an inline mock FFT.
module tb_fft_frame_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_real;
    logic [7:0]  in_imag;
    logic        fft_start;
    logic [63:0] fft_x_real;
    logic [63:0] fft_x_imag;
    logic        fft_done;
    logic [63:0] fft_y_real;
    logic [63:0] fft_y_imag;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_real;
    logic [7:0]  out_imag;
    logic [2:0]  out_index;
    logic        out_last;
    logic        busy;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    fft_frame_ctrl #(.N_PTS(8), .DW(8), .TIMEOUT(64)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_real    (in_real),
        .in_imag    (in_imag),
        .fft_start  (fft_start),
        .fft_x_real (fft_x_real),
        .fft_x_imag (fft_x_imag),
        .fft_done   (fft_done),
        .fft_y_real (fft_y_real),
        .fft_y_imag (fft_y_imag),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_real   (out_real),
        .out_imag   (out_imag),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Advance one clock; everything after this runs 2 ns past the rising edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Feed 8 samples; gaps[k] inserts an idle cycle with junk data before sample k.
    // Returns in the START cycle.
    task automatic fill(input logic [63:0] xr, input logic [63:0] xi, input logic [7:0] gaps);
        for (int k = 0; k < 8; k++) begin
            if (gaps[k]) begin
                in_valid = 1'b0; in_real = 8'hEE; in_imag = 8'hEE;
                step();
            end
            in_valid = 1'b1; in_real = xr[8*k +: 8]; in_imag = xi[8*k +: 8];
            step();
        end
        in_valid = 1'b0; in_real = 8'hEE; in_imag = 8'hEE;
        chk("start_pulse", {63'd0, fft_start}, 64'd1);
        chk("x_real", fft_x_real, xr);
        chk("x_imag", fft_x_imag, xi);
        chk("in_ready_start", {63'd0, in_ready}, 64'd0);
        chk("busy_start", {63'd0, busy}, 64'd1);
    endtask

    // From START: done is seen in the n-th WAIT cycle; returns in first DRAIN cycle.
    task automatic run_fft(input int n, input logic [63:0] yr, input logic [63:0] yi, input logic hold);
        step();
        chk("start_one_cycle", {63'd0, fft_start}, 64'd0);
        chk("in_ready_wait", {63'd0, in_ready}, 64'd0);
        for (int c = 1; c < n; c++) step();
        chk("no_valid_in_wait", {63'd0, out_valid}, 64'd0);
        fft_done = 1'b1; fft_y_real = yr; fft_y_imag = yi;
        step();
        chk("valid_after_done", {63'd0, out_valid}, 64'd1);
        chk("no_timeout_on_done", {63'd0, timeout_err}, 64'd0);
        if (!hold) fft_done = 1'b0;
        // Scramble the FFT port: results must come from the latched copy.
        fft_y_real = 64'h0; fft_y_imag = 64'h0;
    endtask

    // Accept n_acc results under ready pattern pat (bit p%16), checking each cycle.
    task automatic drain(input logic [63:0] er, input logic [63:0] ei, input logic [15:0] pat, input int n_acc);
        int idx = 0;
        int cyc = 0;
        while (idx < n_acc && cyc < 64) begin
            out_ready = pat[cyc % 16];
            chk("out_valid", {63'd0, out_valid}, 64'd1);
            chk("out_index", {61'd0, out_index}, 64'(idx));
            chk("out_real", {56'd0, out_real}, {56'd0, er[8*idx +: 8]});
            chk("out_imag", {56'd0, out_imag}, {56'd0, ei[8*idx +: 8]});
            chk("out_last", {63'd0, out_last}, {63'd0, idx == 7});
            chk("in_ready_drain", {63'd0, in_ready}, 64'd0);
            if (out_ready) idx++;
            step();
            cyc++;
        end
        chk("drain_budget", 64'(idx), 64'(n_acc));
        out_ready = 1'b0;
    endtask

    task automatic after_frame();
        chk("in_ready_back", {63'd0, in_ready}, 64'd1);
        chk("valid_low_after", {63'd0, out_valid}, 64'd0);
        chk("busy_low_after", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [63:0] ramp_r, zero, yr, yi, ar, ai, br, bi;
        logic        seen;
        ramp_r = 64'h0807060504030201;
        zero   = 64'h0;
        yr     = 64'h1716151413121110;
        yi     = 64'hE9EAEBECEDEEEFF0;
        ar     = 64'hA7A6A5A4A3A2A1A0;
        ai     = 64'h5F5E5D5C5B5A5958;
        br     = 64'h7F00FF80017E8102;
        bi     = 64'h0123456789ABCDEF;

        rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0;
        fft_done = 1'b0; fft_y_real = '0; fft_y_imag = '0; out_ready = 1'b0;
        step(); step();
        rst = 1'b0;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_start", {63'd0, fft_start}, 64'd0);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_timeout", {63'd0, timeout_err}, 64'd0);
        chk("rst_x_real", fft_x_real, zero);

        // Ramp with in_valid held; source keeps pushing while not ready.
        fill(ramp_r, zero, 8'h00);
        in_valid = 1'b1; in_real = 8'h99; in_imag = 8'h99;
        run_fft(4, yr, yi, 1'b0);
        chk("x_stable_wait", fft_x_real, ramp_r);
        in_valid = 1'b0;
        drain(yr, yi, 16'hFFFF, 8);
        after_frame();

        // Backpressure 1,0,0,1,0,1,... with input gaps.
        fill(ar, ai, 8'b1010_0110);
        run_fft(3, br, bi, 1'b0);
        drain(br, bi, 16'b1010_1101_0010_1001, 8);
        after_frame();

        // Timeout: done never comes.
        fill(br, bi, 8'h00);
        step();
        seen = 1'b0;
        for (int c = 1; c < 64; c++) begin
            seen = seen | out_valid | timeout_err;
            step();
        end
        chk("timeout_quiet", {63'd0, seen}, 64'd0);
        chk("busy_last_wait", {63'd0, busy}, 64'd1);
        step();
        chk("timeout_pulse", {63'd0, timeout_err}, 64'd1);
        chk("timeout_fill", {63'd0, in_ready}, 64'd1);
        chk("timeout_no_valid", {63'd0, out_valid}, 64'd0);
        step();
        chk("timeout_one_cycle", {63'd0, timeout_err}, 64'd0);
        fill(ramp_r, zero, 8'h00);
        run_fft(5, yr, yi, 1'b0);
        drain(yr, yi, 16'hFFFF, 8);
        after_frame();

        // Done on the 64th WAIT cycle still wins over the timer.
        fill(ar, ai, 8'h00);
        run_fft(64, br, bi, 1'b0);
        drain(br, bi, 16'hFFFF, 8);

        // Reset during WAIT.
        fill(ar, ai, 8'h00);
        step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        chk("rstw_start", {63'd0, fft_start}, 64'd0);
        chk("rstw_valid", {63'd0, out_valid}, 64'd0);
        chk("rstw_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rstw_x_clr", fft_x_real, zero);
        step();
        chk("rstw_no_timeout", {63'd0, timeout_err}, 64'd0);
        fill(ramp_r, zero, 8'h00);
        run_fft(5, yr, yi, 1'b0);
        drain(yr, yi, 16'hFFFF, 8);

        // Reset while DRAIN presents bin 3.
        fill(ar, ai, 8'h00);
        run_fft(2, br, bi, 1'b0);
        drain(br, bi, 16'hFFFF, 3);
        chk("rstd_at3", {61'd0, out_index}, 64'd3);
        rst = 1'b1; step(); rst = 1'b0;
        chk("rstd_start", {63'd0, fft_start}, 64'd0);
        chk("rstd_valid", {63'd0, out_valid}, 64'd0);
        chk("rstd_in_ready", {63'd0, in_ready}, 64'd1);
        fill(ar, ai, 8'h00);
        run_fft(5, yr, yi, 1'b0);
        drain(yr, yi, 16'hFFFF, 8);

        // Level done: held high through DRAIN and the next FILL.
        fill(ramp_r, zero, 8'h00);
        run_fft(5, br, bi, 1'b1);
        drain(br, bi, 16'b0110_1011_0101_1011, 8);
        after_frame();
        fill(ar, ai, 8'b0001_0000);
        fft_done = 1'b0;
        step();
        step(); step();
        chk("lvl_waiting", {63'd0, busy}, 64'd1);
        chk("lvl_no_valid", {63'd0, out_valid}, 64'd0);
        fft_done = 1'b1; fft_y_real = yr; fft_y_imag = yi;
        step();
        fft_done = 1'b0;
        chk("lvl_valid", {63'd0, out_valid}, 64'd1);
        drain(yr, yi, 16'hFFFF, 8);
        after_frame();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
